// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch block.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    ERR
  } state_t;

  // Per-cycle decision from the next-PC logic while in RUN.
  typedef enum logic [2:0] {
    ACT_FETCH,
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_HALT,
    ACT_ERR
  } act_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  // Sign-extended J-type immediate (jal offset, bit 0 always zero).
  function automatic logic [31:0] jal_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select with alignment and end-of-program checks.
// Optional jal prediction is enabled by FETCH_JAL_PREDICT_EN.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_BYTES = 188
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_JAL_PREDICT_EN
  input  logic [31:0]       instr,
  output logic              predicted_c,
`endif
  output act_t              action_c,
  output logic [ADDR_W-1:0] next_pc_c
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);

`ifdef FETCH_JAL_PREDICT_EN
  logic              is_jal;
  logic [ADDR_W-1:0] pred_target;

  // Decode a captured jal and form its target from the current pc.
  always_comb begin
    is_jal      = (instr[6:0] == OPC_JAL);
    pred_target = pc + ADDR_W'(jal_imm(instr));
  end
`endif

  // Priority: redirect > stall > end check > (predicted jal) > sequential.
  always_comb begin
    action_c  = ACT_FETCH;
    next_pc_c = pc + ADDR_W'(4);
`ifdef FETCH_JAL_PREDICT_EN
    predicted_c = 1'b0;
`endif
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        action_c  = ACT_ERR;
        next_pc_c = pc;
      end else begin
        action_c  = ACT_REDIRECT;
        next_pc_c = redirect_pc;
      end
    end else if (stall) begin
      action_c  = ACT_HOLD;
      next_pc_c = pc;
    end else if (pc > LAST_PC) begin
      action_c  = ACT_HALT;
      next_pc_c = pc;
    end
`ifdef FETCH_JAL_PREDICT_EN
    else if (is_jal) begin
      if (pred_target[1:0] != 2'b00) begin
        action_c  = ACT_ERR;
        next_pc_c = pc;
      end else begin
        predicted_c = 1'b1;
        next_pc_c   = pred_target;
      end
    end
`endif
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// and fills the IF/ID register. FETCH_JAL_PREDICT_EN adds 0-bubble jal.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0000_0000),
  parameter int unsigned       IMEM_BYTES = 188
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_JAL_PREDICT_EN
  output logic              ifid_predicted,
`endif
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              halted,
  output logic              misalign_err
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  act_t              action;
  logic [ADDR_W-1:0] next_pc;
`ifdef FETCH_JAL_PREDICT_EN
  logic              predicted;
`endif

  // Memory address is the live PC register.
  assign imem_addr = pc;

  fetch_next_pc #(
    .ADDR_W     (ADDR_W),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_pc (
    .pc             (pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_JAL_PREDICT_EN
    .instr          (imem_rdata),
    .predicted_c    (predicted),
`endif
    .action_c       (action),
    .next_pc_c      (next_pc)
  );

  // Fetch FSM with PC and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
      halted        <= 1'b0;
      misalign_err  <= 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
      ifid_predicted <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          case (action)
            ACT_FETCH: begin
              ifid_instr    <= imem_rdata;
              ifid_pc       <= pc;
              ifid_pc_plus4 <= pc + ADDR_W'(4);
              ifid_valid    <= 1'b1;
              pc            <= next_pc;
`ifdef FETCH_JAL_PREDICT_EN
              ifid_predicted <= predicted;
`endif
            end
            ACT_REDIRECT: begin
              pc         <= next_pc;
              ifid_valid <= 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
              ifid_predicted <= 1'b0;
`endif
            end
            ACT_HALT: begin
              state      <= HALT;
              halted     <= 1'b1;
              ifid_valid <= 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
              ifid_predicted <= 1'b0;
`endif
            end
            ACT_ERR: begin
              state        <= ERR;
              halted       <= 1'b1;
              misalign_err <= 1'b1;
              ifid_valid   <= 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
              ifid_predicted <= 1'b0;
`endif
            end
            default: ;  // ACT_HOLD: PC and IF/ID keep their values
          endcase
        end
        default: ;      // HALT / ERR are left only through reset
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small instruction-memory model.
module tb_fetch_controller;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned IMEM_BYTES = 188;
  localparam int unsigned NWORDS     = IMEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ifid_valid;
  logic [ADDR_W-1:0] ifid_pc;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc_plus4;
  logic              halted;
  logic              misalign_err;
`ifdef FETCH_JAL_PREDICT_EN
  logic              ifid_predicted;
`endif

  logic [31:0] mem [NWORDS];

  int passed = 0;
  int total  = 0;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_JAL_PREDICT_EN
    .ifid_predicted (ifid_predicted),
`endif
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return a marker.
  always_comb begin
    if (imem_addr < ADDR_W'(IMEM_BYTES))
      imem_rdata = mem[int'(imem_addr[7:2])];
    else
      imem_rdata = 32'hdead_beef;
  end

  // addi x0, x0, <addr>: a distinct non-jal word per address.
  function automatic logic [31:0] filler(input int unsigned addr);
    return {12'(addr), 13'd0, 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = filler(4 * i);
    mem[0]  = 32'h1000_0513;
    mem[16] = 32'hfd81_0113;
    mem[46] = 32'h0040_006f;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();

    // Reset state
    chk("rst_addr",    64'(imem_addr), 64'd0);
    chk("rst_valid",   64'(ifid_valid), 64'd0);
    chk("rst_instr",   64'(ifid_instr), 64'h13);
    chk("rst_pc",      64'(ifid_pc), 64'd0);
    chk("rst_pc4",     64'(ifid_pc_plus4), 64'd0);
    chk("rst_halted",  64'(halted), 64'd0);
    chk("rst_misal",   64'(misalign_err), 64'd0);

    // First fetch lands one cycle after pc==0
    reset = 1'b0;
    step();
    chk("f0_addr",  64'(imem_addr), 64'd4);
    chk("f0_valid", 64'(ifid_valid), 64'd1);
    chk("f0_instr", 64'(ifid_instr), 64'h1000_0513);
    chk("f0_pc",    64'(ifid_pc), 64'd0);
    chk("f0_pc4",   64'(ifid_pc_plus4), 64'd4);
    step();
    chk("f1_addr",  64'(imem_addr), 64'd8);
    chk("f1_instr", 64'(ifid_instr), 64'(filler(4)));

    for (int i = 0; i < 7; i++) step();
    chk("pre_stall_addr", 64'(imem_addr), 64'd36);

    // Three stall cycles at pc=36
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  64'(imem_addr), 64'd36);
      chk("stall_pc",    64'(ifid_pc), 64'd32);
      chk("stall_instr", 64'(ifid_instr), 64'(filler(32)));
    end
    stall = 1'b0;
    step();
    chk("resume_pc",   64'(ifid_pc), 64'd36);
    chk("resume_addr", 64'(imem_addr), 64'd40);
    step();
    chk("resume2_pc",  64'(ifid_pc), 64'd40);

    // Redirect to 64 beats a simultaneous stall
    redirect_valid = 1'b1; redirect_pc = 32'd64; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_addr",  64'(imem_addr), 64'd64);
    chk("redir_valid", 64'(ifid_valid), 64'd0);
    step();
    chk("redir_tgt_valid", 64'(ifid_valid), 64'd1);
    chk("redir_tgt_instr", 64'(ifid_instr), 64'hfd81_0113);
    chk("redir_tgt_pc",    64'(ifid_pc), 64'd64);
    chk("redir_next_addr", 64'(imem_addr), 64'd68);

    for (int i = 0; i < 8; i++) step();
    chk("at100_addr", 64'(imem_addr), 64'd100);

    // Misaligned redirect goes to ERR and freezes pc
    redirect_valid = 1'b1; redirect_pc = 32'd66;
    step();
    redirect_valid = 1'b0;
    chk("err_misal",  64'(misalign_err), 64'd1);
    chk("err_halted", 64'(halted), 64'd1);
    chk("err_valid",  64'(ifid_valid), 64'd0);
    chk("err_addr",   64'(imem_addr), 64'd100);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("err_redir_ignored", 64'(imem_addr), 64'd100);
    chk("err_sticky",        64'(misalign_err), 64'd1);

    // Reset clears ERR
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err_rst_addr",  64'(imem_addr), 64'd0);
    chk("err_rst_misal", 64'(misalign_err), 64'd0);
    chk("err_rst_halt",  64'(halted), 64'd0);

    // Mid-run reset at pc=100
    for (int i = 0; i < 25; i++) step();
    chk("run100_addr", 64'(imem_addr), 64'd100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_addr",  64'(imem_addr), 64'd0);
    chk("mid_rst_valid", 64'(ifid_valid), 64'd0);
    chk("mid_rst_misal", 64'(misalign_err), 64'd0);

    // Run to the end of the program
    for (int i = 0; i < 46; i++) step();
    chk("end_addr184", 64'(imem_addr), 64'd184);
    step();
    chk("last_instr", 64'(ifid_instr), 64'h0040_006f);
    chk("last_pc",    64'(ifid_pc), 64'd184);
    chk("last_valid", 64'(ifid_valid), 64'd1);
    chk("last_addr",  64'(imem_addr), 64'd188);
    chk("last_halt0", 64'(halted), 64'd0);
    step();
    chk("halt_flag",  64'(halted), 64'd1);
    chk("halt_valid", 64'(ifid_valid), 64'd0);
    chk("halt_addr",  64'(imem_addr), 64'd188);
    chk("halt_hold_instr", 64'(ifid_instr), 64'h0040_006f);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    chk("halt_redir_ignored", 64'(imem_addr), 64'd188);
    chk("halt_misal0",        64'(misalign_err), 64'd0);

`ifdef FETCH_JAL_PREDICT_EN
    // Predicted jal at 32 jumps straight to 64
    mem[8] = 32'h0200_00ef;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("pred_at32", 64'(imem_addr), 64'd32);
    step();
    chk("pred_addr",  64'(imem_addr), 64'd64);
    chk("pred_flag",  64'(ifid_predicted), 64'd1);
    chk("pred_instr", 64'(ifid_instr), 64'h0200_00ef);
    step();
    chk("pred_after_flag", 64'(ifid_predicted), 64'd0);
    chk("pred_after_pc",   64'(ifid_pc), 64'd64);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
